// File: rtl/cpu5_pkg.sv
// Shared constants and types for the cpu5 multi-cycle control unit.
// Opcode / ALU-op encodings, FSM state enum and the decoder output bundle.
package cpu5_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned OPC_W  = 3;
  localparam int unsigned IR_W   = OPC_W + ADDR_W;

  localparam logic [OPC_W-1:0] OPC_LD  = 3'b000;
  localparam logic [OPC_W-1:0] OPC_ST  = 3'b001;
  localparam logic [OPC_W-1:0] OPC_ADD = 3'b010;
  localparam logic [OPC_W-1:0] OPC_SUB = 3'b011;
  localparam logic [OPC_W-1:0] OPC_AND = 3'b100;
  localparam logic [OPC_W-1:0] OPC_OR  = 3'b101;
  localparam logic [OPC_W-1:0] OPC_JZ  = 3'b110;
  localparam logic [OPC_W-1:0] OPC_HLT = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StMemRd,
    StExec,
    StMemWr,
    StHalt
  } state_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       is_ld;
    logic       is_st;
    logic       is_alu;
    logic       is_jz;
    logic       is_hlt;
  } dec_t;

endpackage

// File: rtl/cpu5_ctrl_unit_decode.sv
// Combinational opcode decoder for the cpu5 control unit.
module cpu5_ctrl_unit_decode
  import cpu5_pkg::*;
(
  input  logic [OPC_W-1:0] opc_i,
  output dec_t             dec_o
);

  always_comb begin
    dec_o        = '0;
    dec_o.alu_op = ALU_ADD;
    unique case (opc_i)
      OPC_LD:  dec_o.is_ld = 1'b1;
      OPC_ST:  dec_o.is_st = 1'b1;
      OPC_ADD: begin
        dec_o.is_alu = 1'b1;
        dec_o.alu_op = ALU_ADD;
      end
      OPC_SUB: begin
        dec_o.is_alu = 1'b1;
        dec_o.alu_op = ALU_SUB;
      end
      OPC_AND: begin
        dec_o.is_alu = 1'b1;
        dec_o.alu_op = ALU_AND;
      end
      OPC_OR: begin
        dec_o.is_alu = 1'b1;
        dec_o.alu_op = ALU_OR;
      end
      OPC_JZ:  dec_o.is_jz  = 1'b1;
      default: dec_o.is_hlt = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu5_ctrl_unit.sv
// Multi-cycle control unit: fetch/decode/memory/exec sequencing around an external ALU.
// Holds PC, IR, ACC, MDR and {CF,SF,ZF}; memories use req/ack handshakes.
module cpu5_ctrl_unit
  import cpu5_pkg::*;
#(
  parameter int unsigned DATA_W = cpu5_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu5_pkg::ADDR_W,
  parameter int unsigned OPC_W  = cpu5_pkg::OPC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    imem_req,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic                    imem_ack,
  input  logic [OPC_W+ADDR_W-1:0] imem_rdata,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [ADDR_W-1:0]       dmem_addr,
  output logic [DATA_W-1:0]       dmem_wdata,
  input  logic                    dmem_ack,
  input  logic [DATA_W-1:0]       dmem_rdata,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [1:0]              alu_op,
  input  logic [DATA_W-1:0]       alu_r,
  input  logic                    alu_cf,
  input  logic                    alu_sf,
  input  logic                    alu_zf,
  output logic [ADDR_W-1:0]       pc,
  output logic [DATA_W-1:0]       acc,
  output logic [2:0]              flags,
  output logic                    halted,
  output logic                    busy
);

  localparam int unsigned IrW = OPC_W + ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [IrW-1:0]      ir_q, ir_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [2:0]          flags_q, flags_d;
  logic                imem_req_q, imem_req_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, dmem_we_d;
  logic                halted_q, halted_d;
  logic                busy_q, busy_d;

  dec_t dec;

  cpu5_ctrl_unit_decode u_decode (
    .opc_i (ir_q[IrW-1:ADDR_W]),
    .dec_o (dec)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    mdr_d   = mdr_q;
    flags_d = flags_q;
    unique case (state_q)
      StIdle: if (start) state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (dec.is_ld || dec.is_alu) begin
          state_d = StMemRd;
        end else if (dec.is_st) begin
          state_d = StMemWr;
        end else if (dec.is_jz) begin
          // JZ looks at the registered ZF, never the live ALU flag.
          if (flags_q[0]) pc_d = ir_q[ADDR_W-1:0];
          state_d = StFetch;
        end else begin
          state_d = StHalt;
        end
      end
      StMemRd: begin
        if (dmem_ack) begin
          if (dec.is_ld) begin
            acc_d   = dmem_rdata;
            state_d = StFetch;
          end else begin
            mdr_d   = dmem_rdata;
            state_d = StExec;
          end
        end
      end
      StExec: begin
        acc_d   = alu_r;
        flags_d = {alu_cf, alu_sf, alu_zf};
        state_d = StFetch;
      end
      StMemWr: if (dmem_ack) state_d = StFetch;
      StHalt:  if (start) state_d = StFetch;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they stay glitch-free Moore signals.
  always_comb begin
    imem_req_d = (state_d == StFetch);
    dmem_req_d = (state_d == StMemRd) || (state_d == StMemWr);
    dmem_we_d  = (state_d == StMemWr);
    halted_d   = (state_d == StHalt);
    busy_d     = (state_d != StIdle) && (state_d != StHalt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      ir_q       <= '0;
      acc_q      <= '0;
      mdr_q      <= '0;
      flags_q    <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      halted_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      acc_q      <= acc_d;
      mdr_q      <= mdr_d;
      flags_q    <= flags_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      halted_q   <= halted_d;
      busy_q     <= busy_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = ir_q[ADDR_W-1:0];
  assign dmem_wdata = acc_q;
  assign alu_a      = acc_q;
  assign alu_b      = mdr_q;
  assign alu_op     = dec.alu_op;
  assign pc         = pc_q;
  assign acc        = acc_q;
  assign flags      = flags_q;
  assign halted     = halted_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cpu5_ctrl_unit.sv
// Directed bench for cpu5_ctrl_unit: behavioural memories with programmable wait
// states, a reference 4-bit ALU, and hand-computed expected results.
module tb_cpu5_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       imem_req, imem_ack;
  logic [4:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       dmem_req, dmem_we, dmem_ack;
  logic [4:0] dmem_addr;
  logic [3:0] dmem_wdata, dmem_rdata;
  logic [3:0] alu_a, alu_b, alu_r;
  logic [1:0] alu_op;
  logic       alu_cf, alu_sf, alu_zf;
  logic [4:0] pc;
  logic [3:0] acc;
  logic [2:0] flags;
  logic       halted, busy;

  cpu5_ctrl_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_r      (alu_r),
    .alu_cf     (alu_cf),
    .alu_sf     (alu_sf),
    .alu_zf     (alu_zf),
    .pc         (pc),
    .acc        (acc),
    .flags      (flags),
    .halted     (halted),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Memories: ack rises after <delay> cycles of a held request.
  logic [7:0] imem [32];
  logic [3:0] dmem [32];
  int         idelay = 0, ddelay = 0;
  int         icnt, dcnt;
  int         irun, drun, ilast, dlast;
  int         wr_cnt;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;

  assign imem_ack   = imem_req && (icnt >= idelay);
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && (dcnt >= ddelay);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt <= 0; dcnt <= 0; irun <= 0; drun <= 0; ilast <= 0; dlast <= 0;
      wr_cnt <= 0; wr_addr <= '0; wr_data <= '0;
    end else begin
      icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
      dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
      if (imem_req) irun <= irun + 1;
      else if (irun != 0) begin ilast <= irun; irun <= 0; end
      if (dmem_req) drun <= drun + 1;
      else if (drun != 0) begin dlast <= drun; drun <= 0; end
      if (dmem_req && dmem_we && dmem_ack) begin
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= dmem_addr;
        wr_data <= dmem_wdata;
      end
    end
  end

  // Reference ALU; CF on SUB means borrow.
  logic [4:0] sum5;
  assign sum5 = {1'b0, alu_a} + {1'b0, alu_b};
  always_comb begin
    alu_r  = '0;
    alu_cf = 1'b0;
    case (alu_op)
      2'b00:   begin alu_r = sum5[3:0]; alu_cf = sum5[4]; end
      2'b01:   begin alu_r = alu_a - alu_b; alu_cf = (alu_a < alu_b); end
      2'b10:   alu_r = alu_a & alu_b;
      default: alu_r = alu_a | alu_b;
    endcase
  end
  assign alu_sf = alu_r[3];
  assign alu_zf = (alu_r == 4'd0);

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 32; i++) imem[i] = 8'hE0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic wait_pc(input logic [4:0] target, input bit equal, input int budget);
    int n = 0;
    while (((pc == target) != equal) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_pc", {31'd0, (pc == target) == equal}, 32'd1);
  endtask

  int cyc;

  initial begin
    for (int i = 0; i < 32; i++) dmem[i] = 4'd0;
    dmem[3] = 4'd3; dmem[4] = 4'd3; dmem[5] = 4'd6; dmem[7] = 4'd3; dmem[8] = 4'd2;

    // 1: reset state and LD 3; ADD 4; HLT with zero-wait memories
    clear_imem();
    imem[0] = 8'h03; imem[1] = 8'h44; imem[2] = 8'hE0;
    do_reset();
    #1;
    check("rst_pc", pc, 0);
    check("rst_acc", acc, 0);
    check("rst_flags", flags, 0);
    check("rst_bsy_hlt_req", {busy, halted, imem_req, dmem_req, dmem_we}, 0);
    pulse_start();
    check("busy_after_start", busy, 1);
    run_to_halt(50, cyc);
    check("t1_cycles", cyc, 9);
    check("t1_acc", acc, 6);
    check("t1_flags", flags, 3'b000);
    check("t1_pc", pc, 3);
    check("t1_busy", busy, 0);

    // 2a: SUB 4 twice then JZ 20 taken
    clear_imem();
    imem[0] = 8'h03; imem[1] = 8'h44; imem[2] = 8'h64; imem[3] = 8'h64; imem[4] = 8'hD4;
    imem[5] = 8'h03;
    do_reset();
    pulse_start();
    run_to_halt(80, cyc);
    check("jz_taken_acc", acc, 0);
    check("jz_taken_flags", flags, 3'b001);
    check("jz_taken_pc", pc, 21);

    // 2b: JZ with ZF=0 falls through
    clear_imem();
    imem[0] = 8'h03; imem[1] = 8'h44; imem[2] = 8'hD4; imem[3] = 8'hE0;
    do_reset();
    pulse_start();
    run_to_halt(80, cyc);
    check("jz_fall_pc", pc, 4);
    check("jz_fall_acc", acc, 6);

    // 3: ST 10 after LD restores acc=6; flags stay 001 through LD and ST
    clear_imem();
    imem[0] = 8'h03; imem[1] = 8'h64; imem[2] = 8'h05; imem[3] = 8'h2A; imem[4] = 8'hE0;
    do_reset();
    pulse_start();
    run_to_halt(80, cyc);
    check("st_wr_count", wr_cnt, 1);
    check("st_wr_addr", wr_addr, 10);
    check("st_wr_data", wr_data, 6);
    check("st_flags", flags, 3'b001);
    check("st_acc", acc, 6);

    // 4: three wait states on both memories
    clear_imem();
    imem[0] = 8'h03; imem[1] = 8'h44; imem[2] = 8'hE0;
    idelay = 3; ddelay = 3;
    do_reset();
    pulse_start();
    run_to_halt(100, cyc);
    check("ws_cycles", cyc, 24);
    check("ws_imem_req_len", ilast, 4);
    check("ws_dmem_req_len", dlast, 4);
    check("ws_acc", acc, 6);
    check("ws_flags", flags, 3'b000);
    check("ws_pc", pc, 3);

    // 5: reset in the middle of a stalled MEM_RD
    idelay = 0; ddelay = 10;
    do_reset();
    pulse_start();
    cyc = 0;
    while (!dmem_req && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("midrd_req_seen", dmem_req, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrd_rst_reqs", {imem_req, dmem_req, dmem_we}, 0);
    check("midrd_rst_state", {busy, halted}, 0);
    check("midrd_rst_pc_acc", {pc, acc}, 0);
    @(negedge clk);
    rst = 1'b0;
    ddelay = 0;
    repeat (4) @(negedge clk);
    check("midrd_idle_hold", {busy, imem_req, pc, acc}, 0);
    pulse_start();
    run_to_halt(50, cyc);
    check("midrd_restart_acc", acc, 6);
    check("midrd_restart_pc", pc, 3);

    // 6: PC wrap 31->0 on fetch of LD at 31, then AND / OR
    clear_imem();
    imem[0] = 8'h03; imem[1] = 8'h64; imem[2] = 8'hDF; imem[31] = 8'h07;
    do_reset();
    pulse_start();
    wait_pc(5'd0, 1'b0, 20);
    imem[0] = 8'hE0;
    wait_pc(5'd31, 1'b1, 40);
    wait_pc(5'd31, 1'b0, 20);
    check("wrap_pc", pc, 0);
    run_to_halt(40, cyc);
    check("wrap_acc", acc, 3);
    check("wrap_flags", flags, 3'b001);
    check("wrap_halt_pc", pc, 1);

    imem[1] = 8'h88; imem[2] = 8'hE0;
    pulse_start();
    run_to_halt(40, cyc);
    check("and_acc", acc, 4'b0010);
    check("and_flags", flags, 3'b000);
    check("and_pc", pc, 3);

    imem[3] = 8'h07; imem[4] = 8'hA8; imem[5] = 8'hE0;
    pulse_start();
    run_to_halt(40, cyc);
    check("or_acc", acc, 4'b0011);
    check("or_zf", flags[0], 0);
    check("or_pc", pc, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu5_ctrl_unit.md
Name: cpu5_ctrl_unit

Overview:
Multi-cycle control unit for the 5-bit-address CPU with direct-addressed LD. It fetches 8-bit instructions, sequences the external 4-bit ALU (A, B, 2-bit OP; R, CF, SF, ZF) and the data memory, and holds PC, IR, ACC and the flag register. Instruction and data memories use req/ack handshakes, so wait states are tolerated.

Parameters:
DATA_W, 4, ACC/ALU/data-memory width
ADDR_W, 5, PC and memory address width
OPC_W, 3, opcode field width; IR width = OPC_W+ADDR_W (8)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; leaves IDLE/HALT
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch address (=PC)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  OPC_W+ADDR_W  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1=write, 0=read; valid while dmem_req
dmem_addr  out  ADDR_W  operand address (=IR[ADDR_W-1:0])
dmem_wdata  out  DATA_W  =ACC
dmem_ack  in  1  access complete; dmem_rdata valid this cycle on read
dmem_rdata  in  DATA_W  read data
alu_a  out  DATA_W  =ACC
alu_b  out  DATA_W  operand register (MDR)
alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
alu_r  in  DATA_W  ALU result
alu_cf, alu_sf, alu_zf  in  1 each  ALU flags
pc  out  ADDR_W  program counter
acc  out  DATA_W  accumulator
flags  out  3  {CF,SF,ZF} registered
halted  out  1  high in HALT
busy  out  1  high outside IDLE/HALT

Behaviour:
- Reset (async): state=IDLE; pc, acc, MDR, IR, flags = 0; all req/we = 0; halted=0, busy=0. Outstanding handshakes are abandoned; memories must tolerate req dropping without ack.
- ISA: opcode=IR[7:5], addr=IR[4:0]. 000 LD (ACC<=M[addr]), 001 ST (M[addr]<=ACC), 010 ADD, 011 SUB, 100 AND, 101 OR (ACC<=ACC op M[addr], flags<=ALU flags), 110 JZ (if ZF then PC<=addr), 111 HLT.
- States: IDLE, FETCH, DECODE, MEM_RD, EXEC, MEM_WR, HALT.
- IDLE: start -> FETCH. Otherwise stay.
- FETCH: imem_req=1, held until imem_ack. On ack: IR<=imem_rdata, PC<=PC+1 (wraps 31->0), -> DECODE. Zero-wait ack (same cycle) gives 1-cycle FETCH.
- DECODE (1 cycle): LD/ALU ops -> MEM_RD; ST -> MEM_WR; JZ: if flags.ZF then PC<=addr, -> FETCH; HLT -> HALT.
- MEM_RD: dmem_req=1, we=0 until dmem_ack. On ack: LD: ACC<=dmem_rdata, -> FETCH. ALU op: MDR<=dmem_rdata, -> EXEC.
- EXEC (1 cycle): alu_op decoded from opcode (combinational, also driven in all states from IR; don't-care outside EXEC). At clock edge ACC<=alu_r, flags<={alu_cf,alu_sf,alu_zf}, -> FETCH.
- MEM_WR: dmem_req=1, we=1, wdata=ACC until dmem_ack; -> FETCH.
- HALT: halted=1; start -> FETCH at current PC (already past HLT).
- start is ignored outside IDLE/HALT.
- LD, ST and JZ never modify flags. JZ tests the registered ZF.
- Minimum latencies (zero-wait memories): LD 3, ST 3, ALU 4, JZ 2, HLT 2 cycles.
- req signals are Moore outputs of the state; req deasserts in the cycle after ack. No back-to-back request reuse.

Decomposition:
- Package cpu5_pkg: opcode constants (OPC_LD..OPC_HLT), ALU op constants (ALU_ADD=00, ALU_SUB=01, ALU_AND=10, ALU_OR=11), state enum, width constants.
- Sub-module cpu5_decode: combinational opcode -> {alu_op, is_ld, is_st, is_alu, is_jz, is_hlt}. FSM and registers stay in top.

Test Plan:
- Reset, then start. Program LD 3; ADD 4; HLT with M[3]=3, M[4]=3, zero-wait memories -> acc=6, flags=000, halted=1, pc=3. Total 9 cycles from FETCH entry.
- Append SUB 4 twice then JZ 20 (M[4]=3, acc=6) -> acc=0, ZF=1, PC=20 after JZ. With ZF=0, JZ falls through (PC=addr of JZ+1).
- ST 10 after acc=6 -> one dmem write, addr=10, wdata=6, we=1. Flags unchanged.
- imem_ack and dmem_ack delayed 3 cycles -> req held stable 4 cycles each. Results identical to the zero-wait run.
- Assert rst mid-MEM_RD (req high) -> all outputs 0 immediately, state IDLE, no ACC update. Restart runs from PC=0.
- PC=31 fetch of LD -> pc wraps to 0. AND/OR with A=4'b0011, B=4'b0010 -> acc=0010 / 0011, ZF=0.
